// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares a single-port, variable-latency memory bus between the IF-stage
// instruction fetch and the MEM-stage data access. The data access belongs to
// the older instruction, so it is served first. The pipeline stays stalled
// until every pending request has been served. It is then released for exactly
// one cycle, the DONE cycle.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   inst_ren/addr  fetch request and address; inst_data is the registered result
//   mem_ren/wen    load / store request (both high is treated as a store)
//   mem_addr/dout  data address and store data; mem_din is the registered load result
//   stall          combinational freeze for all pipeline stages
//   bus_*          registered request side of the shared memory bus
//   bus_rdata/ack  read data and the one-cycle completion pulse
//   bus_err        sticky flag, set when an access is force-completed on timeout
// -----------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_ren,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_data,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_err
);

    // The timeout counter is at least 8 bits wide, and wider if TIMEOUT needs it.
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_WAIT = 2'd1,
        I_WAIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic            d_done_reg, i_done_reg;
    logic [CW-1:0]   tmo_cnt_reg;

    logic            d_pend, d_need, i_need, waiting;
    logic            timeout_hit, complete;
    logic            issue_d, issue_i;
    logic [31:0]     rdata_eff;

    assign d_pend  = mem_ren | mem_wen;
    assign d_need  = d_pend & ~d_done_reg;
    assign i_need  = inst_ren & ~i_done_reg;
    assign waiting = (state_reg == D_WAIT) || (state_reg == I_WAIT);

    // Timeout fires in the TIMEOUT-th request cycle without an ack.
    // If an ack arrives in that same cycle, it wins and no error is flagged.
    assign timeout_hit = bus_req && !bus_ack && (tmo_cnt_reg == CW'(TIMEOUT - 1));
    // Acks outside a wait state are stray and are dropped here.
    assign complete    = waiting && (bus_ack || timeout_hit);
    assign rdata_eff   = bus_ack ? bus_rdata : ERR_DATA;

    // Next-state and issue decisions
    always_comb begin
        state_next = state_reg;
        issue_d    = 1'b0;
        issue_i    = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (d_need) begin
                    issue_d    = 1'b1;
                    state_next = D_WAIT;
                end else if (i_need) begin
                    issue_i    = 1'b1;
                    state_next = I_WAIT;
                end else if (d_pend || inst_ren) begin
                    state_next = DONE;
                end
            end
            D_WAIT: begin
                if (complete) begin
                    // Chain straight into the fetch so there is no idle bus cycle.
                    if (i_need) begin
                        issue_i    = 1'b1;
                        state_next = I_WAIT;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            I_WAIT: begin
                if (complete) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The release cycle (DONE) always drops stall, even though requests are still asserted.
    assign stall = (state_reg != DONE) && (d_need || i_need || waiting);

    // State register and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            d_done_reg  <= 1'b0;
            i_done_reg  <= 1'b0;
            tmo_cnt_reg <= '0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            inst_data   <= '0;
            mem_din     <= '0;
            bus_err     <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (issue_d) begin
                bus_req     <= 1'b1;
                bus_we      <= mem_wen;
                bus_addr    <= mem_addr;
                bus_wdata   <= mem_dout;
                tmo_cnt_reg <= '0;
            end else if (issue_i) begin
                bus_req     <= 1'b1;
                bus_we      <= 1'b0;
                bus_addr    <= inst_addr;
                tmo_cnt_reg <= '0;
            end else if (complete) begin
                bus_req     <= 1'b0;
                tmo_cnt_reg <= '0;
            end else if (bus_req) begin
                tmo_cnt_reg <= tmo_cnt_reg + CW'(1);
            end

            if (complete) begin
                if (state_reg == D_WAIT) begin
                    d_done_reg <= 1'b1;
                    if (!bus_we) begin
                        mem_din <= rdata_eff;
                    end
                end else begin
                    i_done_reg <= 1'b1;
                    inst_data  <= rdata_eff;
                end
                if (!bus_ack) begin
                    bus_err <= 1'b1;
                end
            end

            if (state_reg == DONE) begin
                d_done_reg <= 1'b0;
                i_done_reg <= 1'b0;
            end
        end
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port, variable-latency memory bus between the IF-stage instruction fetch and the MEM-stage data access of the 5-stage MIPS pipeline.
- Serialises the two requests, data first, because the data access belongs to the older instruction.
- Holds the pipeline stalled until every pending request is served, then releases it for exactly one cycle.
- Sits between the datapath and the memory model/bus; its stall output feeds the pipeline controller's stage enables.

Parameters:
- TIMEOUT, 64: max cycles bus_req may wait for bus_ack before the access is force-completed.
- ERR_DATA, 32'hFFFF_FFFF: read data returned on a timed-out read.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- inst_ren  input  1  IF fetch request
- inst_addr  input  32  fetch address
- inst_data  output  32  fetched instruction (registered)
- mem_ren  input  1  MEM-stage load request
- mem_wen  input  1  MEM-stage store request
- mem_addr  input  32  data address
- mem_dout  input  32  store data from datapath
- mem_din  output  32  load data to datapath (registered)
- stall  output  1  freeze all pipeline stages when 1
- bus_req  output  1  bus request (registered)
- bus_we  output  1  bus write enable (registered)
- bus_addr  output  32  bus address (registered)
- bus_wdata  output  32  bus write data (registered)
- bus_rdata  input  32  bus read data, valid with bus_ack
- bus_ack  input  1  one-cycle completion pulse
- bus_err  output  1  sticky timeout flag

Behaviour:
- Reset (sync, rst=1 at posedge):
  - State returns to IDLE.
  - bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, inst_data=0, mem_din=0, bus_err=0.
  - Served flags d_done and i_done cleared; timeout counter cleared.
  - rst wins over every other event, including an ack in the same cycle.
- Definitions:
  - d_pend = mem_ren|mem_wen.
  - If mem_ren and mem_wen are both 1, the access is treated as a write.
- States:
  - IDLE:
    - if d_pend & ~d_done: load bus_* from data side (bus_we=mem_wen), bus_req<=1, go D_WAIT.
    - else if inst_ren & ~i_done: load bus_* from fetch side (bus_we=0), bus_req<=1, go I_WAIT.
    - else if any request is present (all of them served): go DONE.
  - D_WAIT:
    - bus_req and all bus_* stay stable until bus_ack.
    - On ack: bus_req<=0, d_done<=1, mem_din<=bus_rdata only if it was a read.
    - Then, if inst_ren & ~i_done, go directly to I_WAIT with bus_* reloaded from fetch side and bus_req<=1; else go DONE.
  - I_WAIT:
    - On ack: bus_req<=0, i_done<=1, inst_data<=bus_rdata, go DONE.
  - DONE:
    - Lasts one cycle; clears d_done and i_done; goes to IDLE.
- stall:
  - Combinational: 0 in DONE.
  - Otherwise 1 if (d_pend & ~d_done) | (inst_ren & ~i_done), or state is D_WAIT/I_WAIT.
  - With no requests in IDLE, stall=0.
- Pipeline advance:
  - The pipeline advances only on the edge closing the DONE cycle.
  - The datapath holds its request inputs stable while stall=1; the block does not re-sample addresses during a wait.
- Timeout:
  - An 8+ bit counter runs while bus_req=1 and clears on ack or on a new request.
  - When it reaches TIMEOUT without ack: behave as ack with bus_rdata replaced by ERR_DATA, set bus_err<=1 (sticky until rst).
- Stray acks:
  - An ack received in IDLE or DONE is ignored.
  - An ack arriving in the same cycle as the timeout is treated as a normal ack (no error).
- Latency:
  - Zero-wait bus (ack in the first bus_req cycle): single access gives stall=1 for 2 cycles, then stall=0 for 1 cycle.
  - Data+fetch gives 3 stall cycles, then 1 release cycle.

Test Plan:
- Fetch only: inst_ren=1, inst_addr=0x10, ack in same cycle as bus_req with rdata=0x2008_0005 -> bus_addr=0x10, bus_we=0; stall 1,1,0; inst_data=0x2008_0005 in release cycle.
- Load+fetch: mem_ren=1 addr=0x40, inst_ren=1 addr=0x14, zero-wait acks -> data bus cycle first (bus_addr 0x40), then fetch (0x14); stall 1,1,1,0; mem_din and inst_data both updated.
- Store+fetch with 3-cycle ack delay: mem_wen=1 addr=0x80 mem_dout=0xCAFE_F00D -> bus_we=1, bus_wdata=0xCAFE_F00D stable 3 cycles; mem_din unchanged; then fetch issued; stall continuous until DONE.
- Timeout with TIMEOUT=4: load, no ack -> after 4 wait cycles mem_din=0xFFFF_FFFF, bus_err=1 and stays 1 across later good accesses until rst.
- Reset mid-access: rst during D_WAIT, with ack the next cycle -> bus_req=0, stall=0 (no requests), the late ack is ignored, outputs stay 0.
- Back-to-back fetches, inst_ren held 1 with address changed after release -> exactly one bus access per address; no duplicate access during the DONE cycle.
